// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron and its training scheduler.
// Holds the scheduler state encoding, data widths and default latencies.
package perceptron_pkg;

    localparam int X_W           = 18;
    localparam int Y_W           = 48;
    localparam int DEF_N         = 8;
    localparam int DEF_PIPE_LAT  = 3;
    localparam int DEF_TRAIN_LAT = DEF_PIPE_LAT + DEF_N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAIN,
        S_FLUSH,
        S_EVAL,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    // Score tag carried alongside each evaluated sample.
    typedef struct packed {
        logic valid;
        logic sign;
    } tag_t;

endpackage

// File: rtl/training_scheduler_if.sv
// Sample-memory and perceptron signals driven or consumed by the training scheduler.
// master = scheduler side, slave = memory/perceptron side.
interface training_scheduler_if
    import perceptron_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ADDR_W = 8
);
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [X_W*N-1:0]    mem_x;
    logic [Y_W-1:0]      mem_exp_y;
    logic [X_W*N-1:0]    p_x;
    logic                p_train;
    logic [Y_W-1:0]      p_expected_y;
    logic [Y_W-1:0]      p_y;

    modport master (
        output mem_rd, mem_addr, p_x, p_train, p_expected_y,
        input  mem_x, mem_exp_y, p_y
    );

    modport slave (
        input  mem_rd, mem_addr, p_x, p_train, p_expected_y,
        output mem_x, mem_exp_y, p_y
    );
endinterface

// File: rtl/training_scheduler_tag_delay.sv
// Fixed-depth shift register that lines a {valid, sign} score tag up with the
// perceptron output; cleared synchronously when a run is aborted.
module tag_delay
    import perceptron_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t stage [DEPTH];

    // NOTE: this register array is reset (unlike a data memory) because a stale
    // valid tag emerging after reset or abort would be scored as a real sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/training_scheduler.sv
// Epoch controller: alternates a training sweep and a scoring sweep over the
// sample memory until a scoring sweep is error-free or the epoch limit is hit.
module training_scheduler
    import perceptron_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int ADDR_W    = 8,
    parameter int PIPE_LAT  = DEF_PIPE_LAT,
    parameter int TRAIN_LAT = DEF_TRAIN_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    last_addr,
    input  logic [15:0]          max_epochs,
    training_scheduler_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [15:0]          epoch_count,
    output logic [ADDR_W:0]      err_count
);
    localparam int WAIT_W = $clog2(TRAIN_LAT + PIPE_LAT + 3);
    localparam logic [WAIT_W-1:0] FLUSH_LAST = WAIT_W'(TRAIN_LAT + 1);
    localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(PIPE_LAT + 1);

    sched_state_t      state, state_next;
    logic [ADDR_W-1:0] addr_q, last_q;
    logic [15:0]       max_q;
    logic [WAIT_W-1:0] wait_q;
    logic              rd_d1, train_d1, p_valid, p_train_q;
    logic              issue, last_issue, wait_done, accept_start, score_err;
    logic [ADDR_W:0]   err_next;
    tag_t              tag_in, tag_out;
    logic              unused_y_bits;

    assign accept_start = (state == S_IDLE) && start && !abort;
    assign score_err    = tag_out.valid && (bus.p_y[Y_W-1] != tag_out.sign) && !abort;
    assign err_next     = err_count + (ADDR_W+1)'(score_err);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        issue      = (state == S_TRAIN || state == S_EVAL) && !abort;
        last_issue = issue && (addr_q == last_q);
        wait_done  = (state == S_FLUSH && wait_q == FLUSH_LAST) ||
                     (state == S_DRAIN && wait_q == DRAIN_LAST);
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start) state_next = (max_epochs == '0) ? S_EVAL : S_TRAIN;
                S_TRAIN: if (last_issue) state_next = S_FLUSH;
                S_FLUSH: if (wait_done) state_next = S_EVAL;
                S_EVAL:  if (last_issue) state_next = S_DRAIN;
                S_DRAIN: if (wait_done) begin
                    // err_next folds in a score landing on the final drain cycle.
                    if (err_next == '0 || epoch_count == max_q) state_next = S_DONE;
                    else                                        state_next = S_TRAIN;
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            last_q      <= '0;
            max_q       <= '0;
            wait_q      <= '0;
            epoch_count <= '0;
            err_count   <= '0;
            converged   <= 1'b0;
        end else begin
            if (accept_start) begin
                last_q      <= last_addr;
                max_q       <= max_epochs;
                epoch_count <= '0;
                converged   <= 1'b0;
            end
            addr_q <= (issue && !last_issue) ? addr_q + 1'b1 : '0;
            wait_q <= ((state == S_FLUSH || state == S_DRAIN) && !wait_done && !abort)
                      ? wait_q + 1'b1 : '0;
            if (state == S_TRAIN && last_issue) epoch_count <= epoch_count + 1'b1;
            if (state_next == S_EVAL && state != S_EVAL) err_count <= '0;
            else                                         err_count <= err_next;
            if (state == S_DRAIN && state_next == S_DONE) converged <= (err_next == '0);
        end
    end

    // Memory data arrives one cycle after the read and is registered onto p_x.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d1            <= 1'b0;
            train_d1         <= 1'b0;
            p_valid          <= 1'b0;
            p_train_q        <= 1'b0;
            bus.p_x          <= '0;
            bus.p_expected_y <= '0;
        end else if (abort) begin
            rd_d1            <= 1'b0;
            train_d1         <= 1'b0;
            p_valid          <= 1'b0;
            p_train_q        <= 1'b0;
            bus.p_x          <= '0;
            bus.p_expected_y <= '0;
        end else begin
            rd_d1            <= issue;
            train_d1         <= (state == S_TRAIN);
            p_valid          <= rd_d1;
            p_train_q        <= rd_d1 && train_d1;
            bus.p_x          <= rd_d1 ? bus.mem_x : '0;
            bus.p_expected_y <= rd_d1 ? bus.mem_exp_y : '0;
        end
    end

    assign tag_in = '{valid: p_valid && !p_train_q, sign: bus.p_expected_y[Y_W-1]};

    tag_delay #(.DEPTH(PIPE_LAT)) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .clear   (abort),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.mem_rd   = issue;
    assign bus.mem_addr = addr_q;
    assign bus.p_train  = p_train_q && !abort;
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = (state == S_DONE) && !abort;
    assign unused_y_bits = ^bus.p_y[Y_W-2:0];

endmodule

// File: tb/tb_training_scheduler.sv
// Directed bench for training_scheduler with a sample-memory model and a
// scripted perceptron whose accuracy improves with each training pass.
module tb_training_scheduler;
    import perceptron_pkg::*;

    localparam int N        = 8;
    localparam int ADDR_W   = 8;
    localparam int PIPE_LAT = 3;

    logic              clk, rst, start, abort;
    logic [ADDR_W-1:0] last_addr;
    logic [15:0]       max_epochs;
    logic              busy, done, converged;
    logic [15:0]       epoch_count;
    logic [ADDR_W:0]   err_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic            model_clr, xor_mode;
    int              trained;
    logic [Y_W-1:0]  y_pipe [PIPE_LAT];

    training_scheduler_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    training_scheduler #(.N(N), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT), .TRAIN_LAT(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .last_addr   (last_addr),
        .max_epochs  (max_epochs),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .epoch_count (epoch_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample memory: lane 0 carries addr+1, target sign is addr[0]; junk when not read.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_x     <= {{7{18'h00abc}}, 18'(bus.mem_addr) + 18'd1};
            bus.mem_exp_y <= {bus.mem_addr[0], 47'd77};
        end else begin
            bus.mem_x     <= {8{18'h3ffff}};
            bus.mem_exp_y <= '1;
        end
    end

    // After k training passes, samples with index > k are answered wrongly;
    // in xor_mode sample 3 is never learned.
    function automatic logic [Y_W-1:0] predict(input logic [17:0] id, input int passes, input logic xm);
        int   idx;
        logic want, wrong;
        if (id == 18'd0) return '0;
        idx   = int'(id) - 1;
        want  = idx[0];
        wrong = (xm && idx == 3) || (idx >= passes + 1);
        return {want ^ wrong, 47'd1234};
    endfunction

    always @(posedge clk) begin
        if (model_clr)        trained <= 0;
        else if (bus.p_train) trained <= trained + 1;
        y_pipe[0] <= predict(bus.p_x[17:0], trained / 4, xor_mode);
        for (int i = 1; i < PIPE_LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign bus.p_y = y_pipe[PIPE_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] me, input logic xm);
        @(negedge clk);
        xor_mode   = xm;
        model_clr  = 1'b1;
        last_addr  = 8'd3;
        max_epochs = me;
        @(negedge clk);
        model_clr = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes one cycle per negedge until done; restart_at pulses start mid-run.
    task automatic wait_done(input int restart_at, output int trains, output int valids,
                             output int dones, output int align);
        int rd1_cyc, err_cyc;
        logic got;
        trains = 0; valids = 0; dones = 0; align = -1;
        rd1_cyc = -1; err_cyc = -1; got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            if (bus.p_train)    trains++;
            if (bus.p_x != '0)  valids++;
            if (bus.mem_rd && bus.mem_addr == 8'd1 && rd1_cyc < 0) rd1_cyc = i;
            if (err_count != '0 && err_cyc < 0) err_cyc = i;
            if (done) begin
                dones++;
                got = 1'b1;
            end else begin
                start = (i == restart_at);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("run_finished", got, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        if (rd1_cyc >= 0 && err_cyc >= 0) align = err_cyc - rd1_cyc;
    endtask

    initial begin
        int trains, valids, dones, align, seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        last_addr = '0; max_epochs = '0; model_clr = 1'b1; xor_mode = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_p_x", bus.p_x, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_p_train", bus.p_train, 0);
        check("idle_epoch", epoch_count, 0);
        check("idle_err", err_count, 0);
        check("idle_conv", converged, 0);

        // Separable set, converges after the third training pass; extra start mid-run.
        start_run(16'd20, 1'b0);
        check("sep_busy_rise", busy, 1);
        wait_done(10, trains, valids, dones, align);
        check("sep_converged", converged, 1);
        check("sep_epochs", epoch_count, 3);
        check("sep_err", err_count, 0);
        check("sep_done_pulses", dones, 1);
        check("sep_train_cycles", trains, 12);
        check("sep_busy_after", busy, 0);

        // Non-separable set stops at the epoch limit with one residual error.
        start_run(16'd5, 1'b1);
        wait_done(-1, trains, valids, dones, align);
        check("xor_converged", converged, 0);
        check("xor_epochs", epoch_count, 5);
        check("xor_err", err_count, 1);
        check("xor_done_pulses", dones, 1);

        // Zero epoch limit: scoring only, untrained model misses samples 1..3.
        start_run(16'd0, 1'b0);
        wait_done(-1, trains, valids, dones, align);
        check("eval_only_trains", trains, 0);
        check("eval_only_scored", valids, 4);
        check("eval_only_epochs", epoch_count, 0);
        check("eval_only_err", err_count, 3);
        check("eval_only_conv", converged, 0);
        // Sample 1 is scored PIPE_LAT+2 after its read and visible one cycle later.
        check("issue_to_score", align, PIPE_LAT + 3);

        // Abort in the third EVAL cycle of the first epoch.
        start_run(16'd20, 1'b0);
        seen = 0;
        for (int i = 0; i < 200 && seen < 3; i++) begin
            if (seen == 0 && bus.mem_rd)  seen = 1;
            else if (seen == 1 && !bus.mem_rd) seen = 2;
            else if (seen == 2 && bus.mem_rd)  seen = 3;
            if (seen < 3) @(negedge clk);
        end
        check("found_eval", seen, 3);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        #1 check("abort_p_train_now", bus.p_train, 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_p_train", bus.p_train, 0);
        check("abort_p_x", bus.p_x, 0);
        check("abort_epoch_held", epoch_count, 1);
        dones = 0;
        repeat (8) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        check("abort_err_held", err_count, 0);
        start_run(16'd20, 1'b0);
        wait_done(-1, trains, valids, dones, align);
        check("post_abort_conv", converged, 1);
        check("post_abort_epochs", epoch_count, 3);

        // start and abort together while idle: nothing starts.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_mem_rd", bus.mem_rd, 0);

        // Asynchronous reset while training.
        start_run(16'd20, 1'b0);
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            if (bus.p_train) seen = 1;
            else @(negedge clk);
        end
        check("found_train", seen, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_p_train", bus.p_train, 0);
        check("arst_p_x", bus.p_x, 0);
        check("arst_p_exp_y", bus.p_expected_y, 0);
        check("arst_mem_rd", bus.mem_rd, 0);
        check("arst_busy", busy, 0);
        check("arst_epoch", epoch_count, 0);
        @(negedge clk);
        rst = 1'b0;
        valids = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.p_x != '0 || bus.p_train) valids++;
        end
        check("arst_pipe_empty", valids, 0);
        check("arst_err_zero", err_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
